// File: rtl/dvs_fifo_read_arbiter_if.sv
// Read-port bundle between the DVS FIFO arbiter and its event consumers.
interface dvs_fifo_read_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rd_en;
    logic               fifo_empty;
    logic [NUM_REQ-1:0] grant;
    logic               fifo_rd_en;
    logic [OW-1:0]      owner;
    logic               busy;
    logic               timeout_err;
    logic               stray_rd_err;

    // Consumer / FIFO side
    modport master (
        output req, rd_en, fifo_empty,
        input  grant, fifo_rd_en, owner, busy, timeout_err, stray_rd_err
    );

    // Arbiter side
    modport slave (
        input  req, rd_en, fifo_empty,
        output grant, fifo_rd_en, owner, busy, timeout_err, stray_rd_err
    );
endinterface

// File: rtl/dvs_fifo_read_arbiter.sv
// Round-robin arbiter sharing the DVS event FIFO read port among NUM_REQ consumers.
// One outstanding read at a time; stalled owners are revoked after GRANT_TIMEOUT cycles.
module dvs_fifo_read_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned GRANT_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dvs_fifo_read_arbiter_if.slave  bus
);
    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_RD, DATA} state_t;

    state_t             state_q, state_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      owner_inc;
    logic [OW-1:0]      winner;
    logic [OW:0]        scan;
    logic               found;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] owner_mask;
    logic               owner_rd;
    logic               busy_q;
    logic               stray_q, stray_d;
    logic               timeout_c;

    assign owner_mask = NUM_REQ'(1) << owner_q;
    assign owner_rd   = bus.rd_en[owner_q];
    assign owner_inc  = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);

    // First requesting index at or above ptr, wrapping past NUM_REQ-1
    always_comb begin
        winner = '0;
        found  = 1'b0;
        scan   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan = (OW+1)'(ptr_q) + (OW+1)'(i);
            if (scan >= (OW+1)'(NUM_REQ)) begin
                scan = scan - (OW+1)'(NUM_REQ);
            end
            if (!found && bus.req[scan[OW-1:0]]) begin
                found  = 1'b1;
                winner = scan[OW-1:0];
            end
        end
    end

    // Next-state, pointer, timer and registered-output values
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        timer_d   = timer_q;
        grant_d   = '0;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && !bus.fifo_empty) begin
                    owner_d = winner;
                    grant_d = NUM_REQ'(1) << winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (owner_rd) begin
                    timer_d = '0;
                    state_d = DATA;
                end else if (timer_q == TW'(GRANT_TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    ptr_d     = owner_inc;
                    timer_d   = '0;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                ptr_d   = owner_inc;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Only the owner's rd_en during WAIT_RD is legitimate
        stray_d = |(bus.rd_en & ~((state_q == WAIT_RD) ? owner_mask : '0));
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            timer_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            busy_q  <= (state_d != IDLE);
            stray_q <= stray_d;
        end
    end

    // Owner's read enable passes straight to the FIFO while it holds WAIT_RD
    assign bus.fifo_rd_en   = (state_q == WAIT_RD) && owner_rd;
    assign bus.timeout_err  = timeout_c;
    assign bus.grant        = grant_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = busy_q;
    assign bus.stray_rd_err = stray_q;
endmodule

// File: tb/tb_dvs_fifo_read_arbiter.sv
// Self-checking bench for dvs_fifo_read_arbiter: vector table, corner sequences, random vs model.
module tb_dvs_fifo_read_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned G = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dvs_fifo_read_arbiter_if #(.NUM_REQ(N)) bus();

    dvs_fifo_read_arbiter #(.NUM_REQ(N), .GRANT_TIMEOUT(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] rd;
        logic       emp;
        logic [3:0] g;
        logic       b;
        logic       f;
        logic       s;
        logic [1:0] o;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic       b;
        logic       f;
        logic       t;
        logic       w;
        logic       drv;
    } ex_t;

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] rd, input logic e);
        bus.req        = r;
        bus.rd_en      = rd;
        bus.fifo_empty = e;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.rd_en = '0;
        bus.fifo_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[15];
    ex_t  eq[$];

    initial begin
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[5]  = '{4'b0000, 4'b0010, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2};
        tbl[6]  = '{4'b0000, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2};
        tbl[8]  = '{4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};
        tbl[9]  = '{4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};
        tbl[10] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd3};
        tbl[12] = '{4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3};
        tbl[13] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3};

        // Reset state
        do_reset();
        drive(4'b0000, 4'b0000, 1'b0);
        chk("reset_grant", 32'(bus.grant), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_owner", 32'(bus.owner), 32'h0);
        chk("reset_frd", 32'(bus.fifo_rd_en), 32'h0);
        chk("reset_tmo", 32'(bus.timeout_err), 32'h0);
        chk("reset_stray", 32'(bus.stray_rd_err), 32'h0);

        // Vector table: single requester, stray reads, empty FIFO
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].req, tbl[i].rd, tbl[i].emp);
            chk($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(tbl[i].g));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].b));
            chk($sformatf("vec%0d_frd", i), 32'(bus.fifo_rd_en), 32'(tbl[i].f));
            chk($sformatf("vec%0d_stray", i), 32'(bus.stray_rd_err), 32'(tbl[i].s));
            chk($sformatf("vec%0d_owner", i), 32'(bus.owner), 32'(tbl[i].o));
            tick();
        end

        // Fairness: req held at 1011, consumer reads the cycle after its grant
        begin
            int order[3] = '{0, 1, 3};
            int got = 0;
            logic [3:0] pend = '0;
            do_reset();
            for (int c = 0; c < 70 && got < 12; c++) begin
                drive(4'b1011, pend, 1'b0);
                pend = bus.grant;
                if (bus.grant != 4'b0000) begin
                    chk($sformatf("fair_grant%0d", got), 32'(bus.grant), 32'(oh(order[got % 3])));
                    got++;
                end
                tick();
            end
            chk("fair_count", 32'(got), 32'd12);
        end

        // Stalled owner: timeout in the last WAIT_RD cycle, next requester granted 2 cycles later
        begin
            int tmo_n = 0, tmo_c = -1, frd_n = 0, g2_c = -1;
            logic [3:0] g2 = '0;
            do_reset();
            for (int c = 0; c < 14; c++) begin
                drive(4'b0011, 4'b0000, 1'b0);
                if (c == 1) chk("stall_grant0", 32'(bus.grant), 32'h1);
                if (bus.timeout_err) begin tmo_n++; tmo_c = c; end
                if (bus.fifo_rd_en) frd_n++;
                if (c > 1 && bus.grant != 4'b0000 && g2_c < 0) begin g2_c = c; g2 = bus.grant; end
                tick();
            end
            chk("stall_tmo_count", 32'(tmo_n), 32'd1);
            chk("stall_tmo_cycle", 32'(tmo_c), 32'(1 + G));
            chk("stall_frd_count", 32'(frd_n), 32'd0);
            chk("stall_next_cycle", 32'(g2_c), 32'(tmo_c + 2));
            chk("stall_next_grant", 32'(g2), 32'h2);
        end

        // Reset mid-operation in WAIT_RD with a stray error pending
        do_reset();
        drive(4'b0100, 4'b0000, 1'b0);
        tick();
        drive(4'b0000, 4'b0001, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        chk("mid_busy_pre", 32'(bus.busy), 32'h1);
        chk("mid_stray_pre", 32'(bus.stray_rd_err), 32'h1);
        chk("mid_owner_pre", 32'(bus.owner), 32'h2);
        rst_n = 1'b0;
        drive(4'b0000, 4'b0100, 1'b0);
        chk("mid_busy", 32'(bus.busy), 32'h0);
        chk("mid_owner", 32'(bus.owner), 32'h0);
        chk("mid_stray", 32'(bus.stray_rd_err), 32'h0);
        chk("mid_frd", 32'(bus.fifo_rd_en), 32'h0);
        chk("mid_grant", 32'(bus.grant), 32'h0);
        rst_n = 1'b1;
        drive(4'b1000, 4'b0000, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        chk("mid_after_grant", 32'(bus.grant), 32'h8);
        chk("mid_after_owner", 32'(bus.owner), 32'h3);

        // Random traffic against a transaction-level expected-waveform model
        begin
            int m_ptr = 0, m_owner = 0;
            logic exp_stray = 1'b0;
            do_reset();
            eq.delete();
            for (int c = 0; c < 600; c++) begin
                ex_t e;
                bit in_txn;
                logic [3:0] rq, sm, rv;
                logic emp;
                in_txn = (eq.size() != 0);
                if (in_txn) e = eq.pop_front();
                else e = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
                rq  = 4'($urandom);
                emp = ($urandom_range(0, 3) == 0);
                sm  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
                if (in_txn) sm = sm & ~oh(m_owner);
                rv = sm | (e.drv ? oh(m_owner) : 4'b0000);
                drive(rq, rv, emp);
                chk("rnd_grant", 32'(bus.grant), 32'(e.g));
                chk("rnd_busy", 32'(bus.busy), 32'(e.b));
                chk("rnd_frd", 32'(bus.fifo_rd_en), 32'(e.f));
                chk("rnd_tmo", 32'(bus.timeout_err), 32'(e.t));
                chk("rnd_owner", 32'(bus.owner), 32'(m_owner));
                chk("rnd_stray", 32'(bus.stray_rd_err), 32'(exp_stray));
                exp_stray = |(rv & ~(e.w ? oh(m_owner) : 4'b0000));
                if (!in_txn && rq != 4'b0000 && !emp) begin
                    int w, d;
                    bit stall;
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    m_owner = w;
                    m_ptr = (w + 1) % N;
                    d = $urandom_range(0, G + 2);
                    stall = (d >= G);
                    eq.push_back('{oh(w), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
                    for (int k = 0; k < G; k++) begin
                        if (!stall && k > d) break;
                        eq.push_back('{4'b0000, 1'b1, (!stall && k == d), (stall && k == G - 1),
                                       1'b1, (!stall && k == d)});
                    end
                    if (!stall) eq.push_back('{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
